proc_sequencer: RTL

Program sequencer for the 4-bit processor datapath. It holds a small instruction memory loaded over a write port. On `start` it fetches and executes instructions against the two working registers `a0`/`a1` using the add/shift-left ALU, and stops on a halt instruction or at the end of memory. A single-step mode pauses after every instruction so the board can show results on the LEDs.

---
 rtl/proc_sequencer_if.sv | 29 ++
 rtl/proc_sequencer.sv | 98 +++++++++
 2 files changed

// File: rtl/proc_sequencer_if.sv
// Signal bundle between the board/bench (master) and the program sequencer (slave).
// start is a level request sampled on the rising edge: IDLE treats it as "run", PAUSE as "continue".
interface proc_sequencer_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
);
   logic              start;
   logic              step_mode;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [4:0]        prog_data;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] reg_a0;
   logic [DATA_W-1:0] reg_a1;
   logic [DATA_W:0]   result;
   logic [2:0]        dbg_state;

   modport master (
      output start, step_mode, prog_we, prog_addr, prog_data,
      input  busy, done, pc, reg_a0, reg_a1, result, dbg_state
   );

   modport slave (
      input  start, step_mode, prog_we, prog_addr, prog_data,
      output busy, done, pc, reg_a0, reg_a1, result, dbg_state
   );
endinterface

// File: rtl/proc_sequencer.sv
// Program sequencer: loads a small instruction memory, then fetches/executes
// add and shift-left operations on a0/a1, with optional single-step pauses.
module proc_sequencer #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input logic              clk,
   input logic              rst_n,
   proc_sequencer_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PC_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state, state_nx;
   logic [4:0]        mem [DEPTH];
   logic [4:0]        ir;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] a0_q, a1_q;
   logic [DATA_W:0]   res_q;
   logic [DATA_W-1:0] opnd;
   logic [DATA_W:0]   n_ext;
   logic [DATA_W:0]   alu;
   logic              mem_wr_ok;

   // ir: [4] halt, [3] reg select, [2] shift, [1:0] number
   always_comb begin
      opnd  = ir[3] ? a1_q : a0_q;
      n_ext = {{(DATA_W-1){1'b0}}, ir[1:0]};
      alu   = ir[2] ? ({1'b0, opnd} << ir[1:0]) : ({1'b0, opnd} + n_ext);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.start) state_nx = S_FETCH;
         S_FETCH: state_nx = S_EXEC;
         S_EXEC: begin
            if (ir[4] || pc_q == PC_LAST) state_nx = S_DONE;
            else if (bus.step_mode)       state_nx = S_PAUSE;
            else                          state_nx = S_FETCH;
         end
         S_PAUSE: if (bus.start) state_nx = S_FETCH;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= '0;
         ir    <= '0;
         a0_q  <= '0;
         a1_q  <= '0;
         res_q <= '0;
      end else begin
         if (state == S_IDLE && bus.start) pc_q <= '0;
         if (state == S_FETCH) ir <= mem[pc_q];
         // A halt leaves pc pointing at itself so the board can show where the program stopped.
         if (state == S_EXEC && !ir[4]) begin
            res_q <= alu;
            if (ir[3]) a1_q <= alu[DATA_W-1:0];
            else       a0_q <= alu[DATA_W-1:0];
            pc_q <= pc_q + 1'b1;
         end
      end
   end

   assign mem_wr_ok = bus.prog_we && (state == S_IDLE || state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_wr_ok) begin
         mem[bus.prog_addr] <= bus.prog_data;
      end
   end

   assign bus.busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_PAUSE);
   assign bus.done      = (state == S_DONE);
   assign bus.pc        = pc_q;
   assign bus.reg_a0    = a0_q;
   assign bus.reg_a1    = a1_q;
   assign bus.result    = res_q;
   assign bus.dbg_state = state;
endmodule
